wb_arbiter: RTL and testbench

Writeback arbiter directly upstream of the 8×16 register file. Merges three result sources onto the register file's single write port (`regen`, `inaddr`, `in`): the ALU result, the load-data return, and the PC update. PC updates target r7. Each source has a one-entry holding buffer with a valid/ready handshake. Selection uses fixed priority plus an ALU anti-starvation rule and same-destination ordering, so no result is lost or reordered.

---
 rtl/wb_arbiter.sv | 141 ++++++++++++++
 tb/tb_wb_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU, load and PC results onto the single register file write port.
// Each source has a one-entry buffer; fixed priority with ALU anti-starvation and same-dest ordering.
module wb_arbiter #(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [2:0]  alu_dest,
    input  logic [15:0] alu_data,
    output logic        alu_ready,
    input  logic        ld_valid,
    input  logic [2:0]  ld_dest,
    input  logic [15:0] ld_data,
    output logic        ld_ready,
    input  logic        pc_valid,
    input  logic [15:0] pc_data,
    output logic        pc_ready,
    output logic        regen,
    output logic [2:0]  inaddr,
    output logic [15:0] in,
    output logic        busy
);

    localparam logic [1:0] StarveLim = 2'(STARVE_MAX);

    logic        pc_full_q;
    logic [15:0] pc_data_q;
    logic        ld_full_q;
    logic [2:0]  ld_dest_q;
    logic [15:0] ld_data_q;
    logic        alu_full_q;
    logic [2:0]  alu_dest_q;
    logic [15:0] alu_data_q;
    logic        age_q;      // ALU entry is older than the LD entry
    logic [1:0]  starve_q;

    logic grant_pc, grant_ld, grant_alu;
    logic same_dest;
    logic pc_fire, ld_fire, alu_fire;

    always_comb begin
        grant_pc  = 1'b0;
        grant_ld  = 1'b0;
        grant_alu = 1'b0;
        same_dest = ld_full_q && alu_full_q && (ld_dest_q == alu_dest_q);
        if (pc_full_q) begin
            grant_pc = 1'b1;
        end else if (same_dest) begin
            if (age_q) grant_alu = 1'b1;
            else       grant_ld  = 1'b1;
        end else if (alu_full_q && (starve_q == StarveLim)) begin
            grant_alu = 1'b1;
        end else if (ld_full_q) begin
            grant_ld = 1'b1;
        end else if (alu_full_q) begin
            grant_alu = 1'b1;
        end
    end

    // Readys never look at the valids; rst keeps them low while reset is held.
    assign pc_ready  = !rst && (!pc_full_q  || grant_pc);
    assign ld_ready  = !rst && (!ld_full_q  || grant_ld);
    assign alu_ready = !rst && (!alu_full_q || grant_alu);

    assign pc_fire  = pc_valid  && pc_ready;
    assign ld_fire  = ld_valid  && ld_ready;
    assign alu_fire = alu_valid && alu_ready;

    assign busy = pc_full_q || ld_full_q || alu_full_q;

    always_comb begin
        regen  = grant_pc || grant_ld || grant_alu;
        inaddr = 3'd0;
        in     = 16'd0;
        if (grant_pc) begin
            inaddr = 3'd7;
            in     = pc_data_q;
        end else if (grant_ld) begin
            inaddr = ld_dest_q;
            in     = ld_data_q;
        end else if (grant_alu) begin
            inaddr = alu_dest_q;
            in     = alu_data_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_full_q  <= 1'b0;
            pc_data_q  <= 16'd0;
            ld_full_q  <= 1'b0;
            ld_dest_q  <= 3'd0;
            ld_data_q  <= 16'd0;
            alu_full_q <= 1'b0;
            alu_dest_q <= 3'd0;
            alu_data_q <= 16'd0;
            age_q      <= 1'b0;
            starve_q   <= 2'd0;
        end else begin
            if (pc_fire) begin
                pc_full_q <= 1'b1;
                pc_data_q <= pc_data;
            end else if (grant_pc) begin
                pc_full_q <= 1'b0;
            end

            if (ld_fire) begin
                ld_full_q <= 1'b1;
                ld_dest_q <= ld_dest;
                ld_data_q <= ld_data;
            end else if (grant_ld) begin
                ld_full_q <= 1'b0;
            end

            if (alu_fire) begin
                alu_full_q <= 1'b1;
                alu_dest_q <= alu_dest;
                alu_data_q <= alu_data;
            end else if (grant_alu) begin
                alu_full_q <= 1'b0;
            end

            // A new ALU entry is older only if no LD entry remains behind it.
            if (alu_fire && ld_fire) begin
                age_q <= 1'b1;
            end else if (alu_fire) begin
                age_q <= !(ld_full_q && !grant_ld);
            end else if (ld_fire) begin
                age_q <= alu_full_q && !grant_alu;
            end

            if (!alu_full_q || grant_alu) begin
                starve_q <= 2'd0;
            end else if (grant_ld && (starve_q != StarveLim)) begin
                starve_q <= starve_q + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed-vector bench for wb_arbiter: stimulus pushes expected writes into a queue,
// a negedge monitor pops and compares every register file write it observes.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [2:0]  alu_dest;
    logic [15:0] alu_data;
    logic        alu_ready;
    logic        ld_valid;
    logic [2:0]  ld_dest;
    logic [15:0] ld_data;
    logic        ld_ready;
    logic        pc_valid;
    logic [15:0] pc_data;
    logic        pc_ready;
    logic        regen;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic        busy;

    typedef struct {
        logic [2:0]  a;
        logic [15:0] d;
        int          c;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;

    wb_arbiter #(.STARVE_MAX(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_dest  (alu_dest),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .ld_valid  (ld_valid),
        .ld_dest   (ld_dest),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .pc_valid  (pc_valid),
        .pc_data   (pc_data),
        .pc_ready  (pc_ready),
        .regen     (regen),
        .inaddr    (waddr),
        .in        (wdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input logic [2:0] a, input logic [15:0] d, input int c);
        exp_t e;
        e.a = a;
        e.d = d;
        e.c = c;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Monitor: every observed write must match the head of the expected queue.
    always @(negedge clk) begin
        if (regen === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got r%0d=%h at cycle %0d, want no write",
                         waddr, wdata, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (waddr !== e.a || wdata !== e.d || cyc != e.c) begin
                    n_err++;
                    $display("FAIL write: got r%0d=%h at cycle %0d, want r%0d=%h at cycle %0d",
                             waddr, wdata, cyc, e.a, e.d, e.c);
                end
            end
        end
    end

    initial begin
        int accepted;
        logic acc;

        rst = 1'b1;
        alu_valid = 1'b0; alu_dest = 3'd0; alu_data = 16'd0;
        ld_valid  = 1'b0; ld_dest  = 3'd0; ld_data  = 16'd0;
        pc_valid  = 1'b0; pc_data  = 16'd0;

        // Reset defaults
        #12;
        chk("rst_regen", regen, 0);
        chk("rst_busy", busy, 0);
        chk("rst_readys", {pc_ready, ld_ready, alu_ready}, 3'b000);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_readys", {pc_ready, ld_ready, alu_ready}, 3'b111);
        chk("post_rst_regen", regen, 0);
        chk("post_rst_addr_data", {waddr, wdata}, 19'd0);
        chk("post_rst_busy", busy, 0);

        // Single ALU write
        alu_valid = 1'b1; alu_dest = 3'd3; alu_data = 16'h1234;
        push(3'd3, 16'h1234, cyc + 1);
        @(posedge clk); #1;
        alu_valid = 1'b0;
        chk("single_busy_held", busy, 1);
        @(posedge clk); #1;
        chk("single_busy_clear", busy, 0);

        // Three-way collision
        pc_valid = 1'b1;  pc_data = 16'h0040;
        ld_valid = 1'b1;  ld_dest = 3'd2; ld_data = 16'hAAAA;
        alu_valid = 1'b1; alu_dest = 3'd5; alu_data = 16'h5555;
        chk("coll_pc_ready_issue", pc_ready, 1);
        push(3'd7, 16'h0040, cyc + 1);
        push(3'd2, 16'hAAAA, cyc + 2);
        push(3'd5, 16'h5555, cyc + 3);
        @(posedge clk); #1;
        pc_valid = 1'b0; ld_valid = 1'b0; alu_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("coll_pc_ready", pc_ready, 1);
            @(posedge clk); #1;
        end
        chk("coll_busy_clear", busy, 0);

        // Same-dest ordering: ALU r4 older, held off by PC while LD r4 arrives
        pc_valid = 1'b1;  pc_data = 16'h0100;
        alu_valid = 1'b1; alu_dest = 3'd4; alu_data = 16'h0001;
        push(3'd7, 16'h0100, cyc + 1);
        @(posedge clk); #1;
        alu_valid = 1'b0;
        pc_data = 16'h0102;
        ld_valid = 1'b1; ld_dest = 3'd4; ld_data = 16'h0002;
        chk("same_alu_held", alu_ready, 0);
        chk("same_ld_ready", ld_ready, 1);
        push(3'd7, 16'h0102, cyc + 1);
        @(posedge clk); #1;
        pc_valid = 1'b0; ld_valid = 1'b0;
        push(3'd4, 16'h0001, cyc + 1);
        push(3'd4, 16'h0002, cyc + 2);
        repeat (3) @(posedge clk);
        #1;
        chk("same_busy_clear", busy, 0);

        // Starvation: LD streams to r1 while one ALU r6 entry waits
        alu_valid = 1'b1; alu_dest = 3'd6; alu_data = 16'h6666;
        ld_valid = 1'b1;  ld_dest = 3'd1;  ld_data = 16'h1000;
        push(3'd1, 16'h1000, cyc + 1);
        push(3'd1, 16'h1001, cyc + 2);
        push(3'd1, 16'h1002, cyc + 3);
        push(3'd6, 16'h6666, cyc + 4);
        push(3'd1, 16'h1003, cyc + 5);
        accepted = 0;
        for (int k = 0; k < 20 && accepted < 4; k++) begin
            acc = ld_ready;
            @(posedge clk); #1;
            alu_valid = 1'b0;
            if (acc) begin
                accepted++;
                ld_data = ld_data + 16'd1;
                if (accepted == 4) ld_valid = 1'b0;
            end
        end
        chk("starve_ld_accepts", accepted, 4);
        chk("starve_ld_blocked", ld_ready, 0);
        chk("starve_alu_ready", alu_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("starve_busy_clear", busy, 0);

        // Reset mid-operation
        pc_valid = 1'b1;  pc_data = 16'h0200;
        ld_valid = 1'b1;  ld_dest = 3'd3; ld_data = 16'h3333;
        alu_valid = 1'b1; alu_dest = 3'd0; alu_data = 16'h0AAA;
        @(posedge clk); #1;
        pc_valid = 1'b0; ld_valid = 1'b0; alu_valid = 1'b0;
        chk("mid_busy_full", busy, 1);
        chk("mid_regen_before", regen, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_regen_drop", regen, 0);
        chk("mid_addr_data", {waddr, wdata}, 19'd0);
        chk("mid_busy", busy, 0);
        chk("mid_readys", {pc_ready, ld_ready, alu_ready}, 3'b000);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_after_busy", busy, 0);
        chk("mid_after_readys", {pc_ready, ld_ready, alu_ready}, 3'b111);

        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
